// File: rtl/definitions_pkg.sv
// Shared types and sizes for the gaussian window scheduler.
// Latency: n/a (types, constants and one helper only).
// Backpressure: n/a.
package definitions_pkg;

    localparam int PIX_W         = 8;
    localparam int WINDOW_W      = 72;
    localparam int NUM_LINE_BUFS = 4;

    typedef enum logic [0:0] {GW_IDLE, GW_READ} gw_state_t;

    // Rotating line-buffer index: base plus offset, wrapping over four buffers.
    function automatic logic [1:0] buf_idx(input logic [1:0] base, input logic [1:0] off);
        return base + off;
    endfunction

endpackage

// File: rtl/gaussian_line_buffer.sv
// One line of pixel storage: one write port, one synchronous read port.
// Latency: read data appears one cycle after the read address.
// Backpressure: none; the write enable is qualified by the caller.
// Ports: clk; i_wr_en/i_wr_addr/i_wr_dat write side; i_rd_addr in, o_rd_dat out.
module gaussian_line_buffer
    import definitions_pkg::*;
#(
    parameter int DEPTH  = 512,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [PIX_W-1:0]  i_wr_dat,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [PIX_W-1:0]  o_rd_dat
);

    logic [PIX_W-1:0] r_mem [DEPTH];

    // Contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_dat;
        end
        o_rd_dat <= r_mem[i_rd_addr];
    end

endmodule

// File: rtl/gaussian_window_ctrl.sv
// 3x3 window scheduler: raster pixels into four rotating line buffers, windows out.
// Latency: first window 3 cycles after READ entry, i.e. 4 cycles after the 3rd line completes.
// Backpressure: pixel_in_ready low while four lines are held; output side has no ready.
// Ports: clk, rstN (sync, active-low); pixel_in/_valid/_ready in; window_out/_valid, frame_done out.
module gaussian_window_ctrl
    import definitions_pkg::*;
#(
    parameter int IMG_WIDTH  = 512,
    parameter int IMG_HEIGHT = 512
) (
    input  logic                clk,
    input  logic                rstN,
    input  logic [PIX_W-1:0]    pixel_in,
    input  logic                pixel_in_valid,
    output logic                pixel_in_ready,
    output logic [WINDOW_W-1:0] window_out,
    output logic                window_out_valid,
    output logic                frame_done
);

    localparam int ADDR_W = $clog2(IMG_WIDTH);
    localparam int COL_W  = $clog2(IMG_WIDTH + 1);
    localparam int LINE_W = $clog2(IMG_HEIGHT);

    localparam logic [ADDR_W-1:0] LAST_WR_COL  = ADDR_W'(IMG_WIDTH - 1);
    localparam logic [COL_W-1:0]  LAST_RD_COL  = COL_W'(IMG_WIDTH);
    localparam logic [LINE_W-1:0] LAST_RD_LINE = LINE_W'(IMG_HEIGHT - 3);
    localparam logic [LINE_W-1:0] NUM_RD_LINES = LINE_W'(IMG_HEIGHT - 2);

    // Write side
    logic [ADDR_W-1:0] r_wr_col;
    logic [1:0]        r_wr_sel;
    logic [2:0]        r_filled;

    // Read side
    gw_state_t         r_state;
    logic [COL_W-1:0]  r_rd_col;
    logic [1:0]        r_rd_sel;
    logic [LINE_W-1:0] r_rd_line;

    // Stage aligned with line-buffer read data
    logic              r_d1_vld;
    logic              r_d1_first;
    logic              r_d1_zero;
    logic              r_d1_last;
    logic [1:0]        r_d1_sel;

    // Window columns [0]=left [1]=mid [2]=right, each holding rows [0]=top..[2]=bottom
    logic [PIX_W-1:0]  r_win [3][3];
    logic              r_win_vld;
    logic              r_frame_done;

    logic                     w_accept;
    logic                     w_line_done;
    logic                     w_retire;
    logic                     w_frame_end;
    logic [2:0]               w_filled_nxt;
    logic [ADDR_W-1:0]        w_rd_addr;
    logic [NUM_LINE_BUFS-1:0] w_we;
    logic [PIX_W-1:0]         w_rdata [NUM_LINE_BUFS];

    assign pixel_in_ready = (r_filled != 3'd4);
    assign w_accept       = pixel_in_valid && pixel_in_ready;
    assign w_line_done    = w_accept && (r_wr_col == LAST_WR_COL);
    assign w_retire       = (r_state == GW_READ) && (r_rd_col == LAST_RD_COL);
    assign w_frame_end    = w_retire && (r_rd_line == LAST_RD_LINE);

    // At frame end the two lines below the last output row are dropped along
    // with the retiring line; any next-frame lines already held are kept.
    always_comb begin
        w_filled_nxt = r_filled + 3'(w_line_done);
        if (w_frame_end) begin
            w_filled_nxt = w_filled_nxt - 3'd3;
        end else if (w_retire) begin
            w_filled_nxt = w_filled_nxt - 3'd1;
        end
    end

    // The zero-column cycle fetches nothing useful; park the address in range.
    assign w_rd_addr = (r_state == GW_READ && r_rd_col != LAST_RD_COL) ?
                       r_rd_col[ADDR_W-1:0] : '0;

    for (genvar i = 0; i < NUM_LINE_BUFS; i++) begin : g_lbuf
        assign w_we[i] = w_accept && (r_wr_sel == 2'(i));

        gaussian_line_buffer #(
            .DEPTH  (IMG_WIDTH),
            .ADDR_W (ADDR_W)
        ) u_lbuf (
            .clk       (clk),
            .i_wr_en   (w_we[i]),
            .i_wr_addr (r_wr_col),
            .i_wr_dat  (pixel_in),
            .i_rd_addr (w_rd_addr),
            .o_rd_dat  (w_rdata[i])
        );
    end

    // Write counters, read FSM and line bookkeeping
    always_ff @(posedge clk) begin
        if (!rstN) begin
            r_wr_col  <= '0;
            r_wr_sel  <= '0;
            r_filled  <= '0;
            r_state   <= GW_IDLE;
            r_rd_col  <= '0;
            r_rd_sel  <= '0;
            r_rd_line <= '0;
        end else begin
            r_filled <= w_filled_nxt;

            if (w_accept) begin
                if (w_line_done) begin
                    r_wr_col <= '0;
                    r_wr_sel <= r_wr_sel + 2'd1;
                end else begin
                    r_wr_col <= r_wr_col + ADDR_W'(1);
                end
            end

            case (r_state)
                GW_IDLE: begin
                    // Looking at next-cycle fill lets READ start the cycle after line 3 lands.
                    if (w_filled_nxt >= 3'd3 && r_rd_line < NUM_RD_LINES) begin
                        r_state  <= GW_READ;
                        r_rd_col <= '0;
                    end
                end
                GW_READ: begin
                    if (r_rd_col == LAST_RD_COL) begin
                        r_state <= GW_IDLE;
                        if (w_frame_end) begin
                            // Skip the two discarded lines: next frame's line 0 is three buffers on.
                            r_rd_sel  <= r_rd_sel + 2'd3;
                            r_rd_line <= '0;
                        end else begin
                            r_rd_sel  <= r_rd_sel + 2'd1;
                            r_rd_line <= r_rd_line + LINE_W'(1);
                        end
                    end else begin
                        r_rd_col <= r_rd_col + COL_W'(1);
                    end
                end
                default: r_state <= GW_IDLE;
            endcase
        end
    end

    // Window assembly: one column per read-data cycle
    always_ff @(posedge clk) begin
        if (!rstN) begin
            r_d1_vld     <= 1'b0;
            r_d1_first   <= 1'b0;
            r_d1_zero    <= 1'b0;
            r_d1_last    <= 1'b0;
            r_d1_sel     <= '0;
            r_win_vld    <= 1'b0;
            r_frame_done <= 1'b0;
            for (int c = 0; c < 3; c++) begin
                for (int r = 0; r < 3; r++) begin
                    r_win[c][r] <= '0;
                end
            end
        end else begin
            r_d1_vld   <= (r_state == GW_READ);
            r_d1_first <= (r_rd_col == '0);
            r_d1_zero  <= (r_rd_col == LAST_RD_COL);
            r_d1_last  <= (r_rd_line == LAST_RD_LINE);
            r_d1_sel   <= r_rd_sel;

            if (r_d1_vld) begin
                // Column 0 enters with zeros at left/mid so column -1 reads as padding.
                if (r_d1_first) begin
                    for (int r = 0; r < 3; r++) begin
                        r_win[0][r] <= '0;
                        r_win[1][r] <= '0;
                    end
                end else begin
                    for (int r = 0; r < 3; r++) begin
                        r_win[0][r] <= r_win[1][r];
                        r_win[1][r] <= r_win[2][r];
                    end
                end
                for (int r = 0; r < 3; r++) begin
                    r_win[2][r] <= r_d1_zero ? '0 : w_rdata[buf_idx(r_d1_sel, 2'(r))];
                end
            end

            // A window is complete once the column right of its centre is in.
            r_win_vld    <= r_d1_vld && !r_d1_first;
            r_frame_done <= r_d1_vld && r_d1_zero && r_d1_last;
        end
    end

    always_comb begin
        window_out = '0;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                window_out[(r*3+c)*PIX_W +: PIX_W] = r_win[c][r];
            end
        end
    end

    assign window_out_valid = r_win_vld;
    assign frame_done       = r_frame_done;

endmodule

// File: tb/tb_gaussian_window_ctrl.sv
// Scoreboard bench for gaussian_window_ctrl at IMG_WIDTH=IMG_HEIGHT=4.
// Latency: expected windows are queued when their third line is accepted.
// Backpressure: driver holds each pixel until the DUT takes it.
module tb_gaussian_window_ctrl;

    localparam int W = 4;
    localparam int H = 4;

    logic        clk = 1'b0;
    logic        rstN;
    logic [7:0]  pixel_in;
    logic        pixel_in_valid;
    logic        pixel_in_ready;
    logic [71:0] window_out;
    logic        window_out_valid;
    logic        frame_done;

    always #5 clk = ~clk;

    gaussian_window_ctrl #(
        .IMG_WIDTH  (W),
        .IMG_HEIGHT (H)
    ) dut (
        .clk              (clk),
        .rstN             (rstN),
        .pixel_in         (pixel_in),
        .pixel_in_valid   (pixel_in_valid),
        .pixel_in_ready   (pixel_in_ready),
        .window_out       (window_out),
        .window_out_valid (window_out_valid),
        .frame_done       (frame_done)
    );

    typedef struct packed {
        logic [71:0] win;
        logic        fd;
    } exp_t;

    exp_t        exp_q [$];
    exp_t        mon_e;
    logic [71:0] obs_q [$];
    int          burst_q [$];

    int n_vec = 0;
    int n_bad = 0;
    int cyc = 0;
    int win_cnt = 0;
    int fd_cnt = 0;
    int stall_cnt = 0;
    int run_len = 0;
    int last_end = -1;
    int t_line3 = 0;
    int m_cnt = 0;
    logic [7:0] img [H][W];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(input string name, input logic [71:0] act, input logic [71:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Reference: a frame is an H x W image; output row y (1..H-2) is emitted once
    // image line y+1 is complete, one window per column, zero outside the image.
    task automatic model_accept(input logic [7:0] p, input int t);
        int line = m_cnt / W;
        int col  = m_cnt % W;
        img[line][col] = p;
        m_cnt++;
        if (col == W - 1) begin
            if (line == 2) t_line3 = t;
            if (line >= 2) begin
                for (int c = 0; c < W; c++) begin
                    exp_t e;
                    e.win = '0;
                    for (int r = 0; r < 3; r++) begin
                        for (int k = 0; k < 3; k++) begin
                            int x = c + k - 1;
                            if (x >= 0 && x < W) e.win[(r*3+k)*8 +: 8] = img[line-2+r][x];
                        end
                    end
                    e.fd = (line == H - 1) && (c == W - 1);
                    exp_q.push_back(e);
                end
            end
            if (line == H - 1) m_cnt = 0;
        end
    endtask

    // Monitor
    always @(negedge clk) begin
        if (!rstN) begin
            run_len  = 0;
            last_end = -1;
        end else if (window_out_valid) begin
            if (run_len == 0) begin
                burst_q.push_back(cyc);
                if (last_end >= 0) check("burst_gap_ge2", 72'((cyc - last_end - 1) >= 2), 72'd1);
            end
            run_len++;
            win_cnt++;
            obs_q.push_back(window_out);
            if (frame_done) fd_cnt++;
            if (exp_q.size() == 0) begin
                check("unexpected_window", 72'(window_out_valid), 72'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check("window", window_out, mon_e.win);
                check("frame_done", 72'(frame_done), 72'(mon_e.fd));
            end
        end else begin
            if (frame_done) check("frame_done_no_valid", 72'(frame_done), 72'd0);
            if (run_len != 0) begin
                check("burst_len", 72'(run_len), 72'(W));
                run_len  = 0;
                last_end = cyc - 1;
            end
        end
    end

    task automatic send_pix(input logic [7:0] p);
        bit acc = 1'b0;
        int tries = 0;
        int t = 0;
        pixel_in       = p;
        pixel_in_valid = 1'b1;
        while (!acc && tries < 200) begin
            @(negedge clk);
            acc = pixel_in_ready;
            t   = cyc;
            @(posedge clk);
            #1;
            if (!acc) stall_cnt++;
            tries++;
        end
        pixel_in_valid = 1'b0;
        if (acc) model_accept(p, t);
        else     check("send_timeout", 72'(acc), 72'd1);
    endtask

    task automatic idle(input int n);
        pixel_in_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int k = 0;
        while (exp_q.size() != 0 && k < 300) begin
            @(posedge clk);
            k++;
        end
        repeat (8) @(posedge clk);
        #1;
        check("drain_empty", 72'(exp_q.size()), 72'd0);
    endtask

    task automatic clear_stats();
        win_cnt   = 0;
        fd_cnt    = 0;
        stall_cnt = 0;
        obs_q.delete();
        burst_q.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        @(negedge clk);
        check({tag, "_window_out"}, window_out, 72'd0);
        check({tag, "_valid"}, 72'(window_out_valid), 72'd0);
        check({tag, "_frame_done"}, 72'(frame_done), 72'd0);
        check({tag, "_ready"}, 72'(pixel_in_ready), 72'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic reset_pulse(input int n);
        rstN           = 1'b0;
        pixel_in_valid = 1'b0;
        exp_q.delete();
        m_cnt = 0;
        repeat (n) @(posedge clk);
        #1;
        rstN = 1'b1;
    endtask

    logic [71:0] k_r1c0;
    logic [71:0] k_r2c3;
    logic [71:0] tmp;

    initial begin
        k_r1c0 = {8'd10, 8'd9, 8'd0, 8'd6, 8'd5, 8'd0, 8'd2, 8'd1, 8'd0};
        k_r2c3 = {8'd0, 8'd16, 8'd15, 8'd0, 8'd12, 8'd11, 8'd0, 8'd8, 8'd7};
        pixel_in       = '0;
        pixel_in_valid = 1'b0;
        rstN           = 1'b0;
        @(posedge clk);
        #1;
        reset_pulse(2);
        check_reset_outputs("por");

        // Basic frame, continuous valid
        clear_stats();
        for (int p = 1; p <= 16; p++) send_pix(8'(p));
        drain();
        check("s1_windows", 72'(win_cnt), 72'd8);
        check("s1_frame_done", 72'(fd_cnt), 72'd1);
        check("s1_r1c0", (obs_q.size() > 0) ? obs_q[0] : 72'hx, k_r1c0);
        check("s1_r2c3", (obs_q.size() > 7) ? obs_q[7] : 72'hx, k_r2c3);
        check("s1_first_latency", 72'((burst_q.size() > 0) ? burst_q[0] - t_line3 : -1), 72'd4);

        // Line 4 completes in the same cycle as the first READ retire
        clear_stats();
        for (int p = 0; p < 12; p++) send_pix(8'(40 + p));
        idle(1);
        for (int p = 12; p < 16; p++) send_pix(8'(40 + p));
        drain();
        check("s3_no_stall", 72'(stall_cnt), 72'd0);
        check("s3_windows", 72'(win_cnt), 72'd8);

        // Backpressure: two random frames with valid held high
        clear_stats();
        for (int p = 0; p < 2 * W * H; p++) send_pix(8'($urandom_range(0, 255)));
        drain();
        check("s2_stalled", 72'(stall_cnt > 0), 72'd1);
        check("s2_windows", 72'(win_cnt), 72'd16);
        check("s2_frame_done", 72'(fd_cnt), 72'd2);

        // Back-to-back frames
        clear_stats();
        for (int p = 1; p <= 16; p++) send_pix(8'(p));
        for (int p = 101; p <= 116; p++) send_pix(8'(p));
        drain();
        check("s4_windows", 72'(win_cnt), 72'd16);
        check("s4_frame_done", 72'(fd_cnt), 72'd2);
        tmp = (obs_q.size() > 8) ? obs_q[8] : 72'hx;
        check("s4_f2_centre", 72'(tmp[39:32]), 72'd105);

        // Reset mid-frame, then a fresh frame
        clear_stats();
        for (int p = 1; p <= 10; p++) send_pix(8'(p));
        reset_pulse(1);
        check_reset_outputs("midrst");
        clear_stats();
        for (int p = 1; p <= 16; p++) send_pix(8'(p));
        drain();
        check("s5_windows", 72'(win_cnt), 72'd8);
        check("s5_frame_done", 72'(fd_cnt), 72'd1);
        check("s5_r1c0", (obs_q.size() > 0) ? obs_q[0] : 72'hx, k_r1c0);
        check("s5_r2c3", (obs_q.size() > 7) ? obs_q[7] : 72'hx, k_r2c3);

        // Random pixels with random input gaps
        clear_stats();
        for (int p = 0; p < 3 * W * H; p++) begin
            if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 6));
            send_pix(8'($urandom_range(0, 255)));
        end
        drain();
        check("s6_windows", 72'(win_cnt), 72'd24);
        check("s6_frame_done", 72'(fd_cnt), 72'd3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
